// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: watches a multiplexed active-low 7-segment bus,
// decodes each stable digit and hands out one frame per full scan.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   seg_n         segment lines g..a (bit 6 = g), active-low
//   an_n          digit enables, active-low, one-hot-low when valid
//   frame_valid   frame_data/frame_err hold an unaccepted frame
//   frame_ready   consumer takes the frame when high with frame_valid
//   frame_data    decoded codes, digit i at [4i+3:4i]
//   frame_err     some digit of this frame was unrecognized
//   overflow      sticky: a frame completed while one was pending
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [4*DIGITS-1:0]   frame_data,
    output logic                  frame_err,
    output logic                  overflow
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [6:0]              seg_q;
    logic [6:0]              seg_p;
    logic [DIGITS-1:0]       an_q;
    logic [DIGITS-1:0]       an_p;
    logic [CW-1:0]           cnt;
    logic [DIGITS-1:0]       mask;
    logic [DIGITS-1:0][3:0]  dig_code;
    logic [DIGITS-1:0]       dig_err;

    logic [3:0]              low_cnt;
    logic                    stable;
    logic                    capture;
    logic                    complete;
    logic                    accept;
    logic [4:0]              dec;
    logic [4*DIGITS-1:0]     fd_next;
    logic [DIGITS-1:0]       fe_next;

    // Returns {error, code}.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b0, 4'h0};
            7'b1111001: r = {1'b0, 4'h1};
            7'b0100100: r = {1'b0, 4'h2};
            7'b0110000: r = {1'b0, 4'h3};
            7'b0011001: r = {1'b0, 4'h4};
            7'b0010010: r = {1'b0, 4'h5};
            7'b0000010: r = {1'b0, 4'h6};
            7'b1111000: r = {1'b0, 4'h7};
            7'b0000000: r = {1'b0, 4'h8};
            7'b0011000: r = {1'b0, 4'h9};
            7'b1111111: r = {1'b0, 4'hF};
            default:    r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    always_comb begin
        low_cnt = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) low_cnt = low_cnt + 4'd1;
        end
    end

    assign stable  = (seg_q == seg_p) && (an_q == an_p)
                     && (low_cnt == 4'd1);
    // Fires on the single edge where the run length reaches the target;
    // the counter then saturates so a held digit is captured only once.
    assign capture = stable && (cnt == CNT_MAX - CW'(1));
    assign complete = capture && (&(mask | ~an_q));
    assign accept  = frame_valid && frame_ready;
    assign dec     = decode(seg_q);

    // Digit registers as they will be after this edge, so a completing
    // capture lands its own digit in the frame.
    always_comb begin
        fd_next = '0;
        fe_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && !an_q[i]) begin
                fd_next[4*i +: 4] = dec[3:0];
                fe_next[i]        = dec[4];
            end else begin
                fd_next[4*i +: 4] = dig_code[i];
                fe_next[i]        = dig_err[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q       <= 7'h7F;
            seg_p       <= 7'h7F;
            an_q        <= '1;
            an_p        <= '1;
            cnt         <= '0;
            mask        <= '0;
            dig_code    <= '1;
            dig_err     <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '1;
            frame_err   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            seg_q <= seg_n;
            an_q  <= an_n;
            seg_p <= seg_q;
            an_p  <= an_q;

            if (!stable) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end

            if (capture) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (!an_q[i]) begin
                        dig_code[i] <= dec[3:0];
                        dig_err[i]  <= dec[4];
                    end
                end
                mask <= complete ? '0 : (mask | ~an_q);
            end

            if (complete && (!frame_valid || accept)) begin
                frame_valid <= 1'b1;
                frame_data  <= fd_next;
                frame_err   <= |fe_next;
            end else begin
                if (complete) overflow <= 1'b1;
                if (accept) frame_valid <= 1'b0;
            end
        end
    end

endmodule
